// File: rtl/stream_checker_pkg.sv
// rtl/stream_checker_pkg.sv - shared types, config field positions and helpers for stream_checker
package stream_checker_pkg;

    typedef enum logic [1:0] {
        IDLE,
        IN_FRAME,
        RESYNC
    } state_e;

    localparam int CFG_LEN_LSB     = 0;
    localparam int CFG_LEN_MSB     = 7;
    localparam int CFG_THR_LSB     = 8;
    localparam int CFG_THR_MSB     = 11;
    localparam int CFG_SEQ_RESTART = 12;
    localparam int CFG_SEQ_CHECK   = 13;

    // Fibonacci taps 16,14,13,11 expressed on bit indices 15,13,12,10
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
        logic [31:0] max_val;
        max_val = 32'hFFFF_FFFF >> (32 - width);
        return (value == max_val) ? value : value + 32'd1;
    endfunction

endpackage

// File: rtl/stream_checker_lfsr_throttle.sv
// rtl/stream_checker_lfsr_throttle.sv - free-running LFSR driving a registered, throttled ready
module lfsr_throttle
    import stream_checker_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] throttle,
    output logic       ready
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        ready_q;
    logic        ready_d;

    always_comb begin
        lfsr_d  = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
        ready_d = (throttle == 4'd0) || (lfsr_d[3:0] >= throttle);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q  <= LFSR_SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;

endmodule

// File: rtl/stream_checker.sv
// rtl/stream_checker.sv - AXI-Stream sink checking frame length and incrementing data, with throttled ready
module stream_checker
    import stream_checker_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [15:0]           confi,
    input  logic                  clear_err,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [CNT_WIDTH-1:0]  frames_ok,
    output logic [CNT_WIDTH-1:0]  frames_bad,
    output logic [CNT_WIDTH-1:0]  err_data_count,
    output logic [2:0]            err_flags,
    output logic                  busy
);

    state_e                state_q, state_d;
    logic [13:0]           cfg_q, cfg_d;
    logic [7:0]            beat_idx_q, beat_idx_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  bad_q, bad_d;
    logic [CNT_WIDTH-1:0]  frames_ok_q, frames_ok_d;
    logic [CNT_WIDTH-1:0]  frames_bad_q, frames_bad_d;
    logic [CNT_WIDTH-1:0]  err_data_q, err_data_d;
    logic [2:0]            err_flags_q, err_flags_d;
    logic                  busy_q, busy_d;

    logic                  accept;
    logic [13:0]           cfg;
    logic [7:0]            frame_len;
    logic [7:0]            last_idx;
    logic [DATA_WIDTH-1:0] exp_use;
    logic                  mismatch;
    logic                  frame_bad;
    logic                  inc_ok, inc_bad, set_early, set_miss;
    logic                  unused_cfg_bits;

    assign unused_cfg_bits = ^confi[15:14];

    // In IDLE the live config applies so a frame-start beat sees the value being captured
    assign cfg = (state_q == IDLE) ? confi[13:0] : cfg_q;

    lfsr_throttle u_lfsr_throttle (
        .clk      (clk),
        .reset    (reset),
        .throttle (cfg[CFG_THR_MSB:CFG_THR_LSB]),
        .ready    (s_axis_tready)
    );

    always_comb begin
        accept    = s_axis_tvalid & s_axis_tready;
        frame_len = cfg[CFG_LEN_MSB:CFG_LEN_LSB];
        last_idx  = frame_len - 8'd1;
        exp_use   = (state_q == IDLE && cfg[CFG_SEQ_RESTART]) ? '0 : exp_q;
        mismatch  = accept && (state_q != RESYNC) && cfg[CFG_SEQ_CHECK] && (s_axis_tdata != exp_use);
        frame_bad = bad_q | mismatch;

        state_d    = state_q;
        cfg_d      = (state_q == IDLE) ? confi[13:0] : cfg_q;
        beat_idx_d = beat_idx_q;
        exp_d      = exp_q;
        bad_d      = bad_q;
        inc_ok     = 1'b0;
        inc_bad    = 1'b0;
        set_early  = 1'b0;
        set_miss   = 1'b0;

        if (accept) begin
            case (state_q)
                IDLE: begin
                    exp_d = s_axis_tdata + DATA_WIDTH'(1);
                    if (s_axis_tlast) begin
                        set_early = (frame_len != 8'd1);
                        inc_bad   = set_early | mismatch;
                        inc_ok    = ~(set_early | mismatch);
                    end else if (frame_len == 8'd1) begin
                        set_miss = 1'b1;
                        inc_bad  = 1'b1;
                        state_d  = RESYNC;
                    end else begin
                        state_d    = IN_FRAME;
                        beat_idx_d = 8'd1;
                        bad_d      = mismatch;
                    end
                end
                IN_FRAME: begin
                    exp_d = s_axis_tdata + DATA_WIDTH'(1);
                    if (s_axis_tlast) begin
                        set_early = (beat_idx_q != last_idx);
                        inc_bad   = set_early | frame_bad;
                        inc_ok    = ~(set_early | frame_bad);
                        state_d   = IDLE;
                    end else if (beat_idx_q == last_idx) begin
                        set_miss = 1'b1;
                        inc_bad  = 1'b1;
                        state_d  = RESYNC;
                    end else begin
                        beat_idx_d = beat_idx_q + 8'd1;
                        bad_d      = frame_bad;
                    end
                end
                RESYNC: begin
                    if (s_axis_tlast) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);

        // A coinciding clear wins over any increment or flag set in the same cycle
        if (clear_err) begin
            frames_ok_d  = '0;
            frames_bad_d = '0;
            err_data_d   = '0;
            err_flags_d  = '0;
        end else begin
            frames_ok_d  = inc_ok ? CNT_WIDTH'(sat_inc(32'(frames_ok_q), CNT_WIDTH)) : frames_ok_q;
            frames_bad_d = inc_bad ? CNT_WIDTH'(sat_inc(32'(frames_bad_q), CNT_WIDTH)) : frames_bad_q;
            err_data_d   = mismatch ? CNT_WIDTH'(sat_inc(32'(err_data_q), CNT_WIDTH)) : err_data_q;
            err_flags_d  = err_flags_q | {mismatch, set_miss, set_early};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cfg_q        <= '0;
            beat_idx_q   <= '0;
            exp_q        <= '0;
            bad_q        <= 1'b0;
            frames_ok_q  <= '0;
            frames_bad_q <= '0;
            err_data_q   <= '0;
            err_flags_q  <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_q        <= cfg_d;
            beat_idx_q   <= beat_idx_d;
            exp_q        <= exp_d;
            bad_q        <= bad_d;
            frames_ok_q  <= frames_ok_d;
            frames_bad_q <= frames_bad_d;
            err_data_q   <= err_data_d;
            err_flags_q  <= err_flags_d;
            busy_q       <= busy_d;
        end
    end

    assign frames_ok      = frames_ok_q;
    assign frames_bad     = frames_bad_q;
    assign err_data_count = err_data_q;
    assign err_flags      = err_flags_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_stream_checker.sv
// tb/tb_stream_checker.sv - scoreboard bench for stream_checker with directed and random frames
module tb_stream_checker;

    localparam int DW = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [15:0]   confi = 16'h0;
    logic          clear_err = 1'b0;
    logic [DW-1:0] tdata = '0;
    logic          tvalid = 1'b0;
    logic          tlast = 1'b0;
    logic          tready;
    logic [CW-1:0] frames_ok, frames_bad, err_data_count;
    logic [2:0]    err_flags;
    logic          busy;

    stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .confi          (confi),
        .clear_err      (clear_err),
        .s_axis_tdata   (tdata),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_tlast   (tlast),
        .frames_ok      (frames_ok),
        .frames_bad     (frames_bad),
        .err_data_count (err_data_count),
        .err_flags      (err_flags),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] ok;
        logic [CW-1:0] bad;
        logic [CW-1:0] derr;
        logic [2:0]    flags;
        logic          busy;
    } snap_t;

    snap_t sbq[$];
    int checks = 0;
    int failures = 0;

    logic [DW-1:0] m_exp;
    logic [CW-1:0] m_ok, m_bad, m_derr;
    logic [2:0]    m_flags;

    bit cnt_en = 1'b0;
    int cyc_tot = 0;
    int cyc_rdy = 0;

    function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    initial begin
        snap_t e;
        logic  acc;
        forever begin
            @(negedge clk);
            #1;
            acc = tvalid && tready && reset;
            @(posedge clk);
            #1;
            if (acc) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_beat actual=accepted required=none_pending");
                end else begin
                    e = sbq.pop_front();
                    chk("frames_ok", 32'(frames_ok), 32'(e.ok));
                    chk("frames_bad", 32'(frames_bad), 32'(e.bad));
                    chk("err_data_count", 32'(err_data_count), 32'(e.derr));
                    chk("err_flags", 32'(err_flags), 32'(e.flags));
                    chk("busy", 32'(busy), 32'(e.busy));
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cnt_en) begin
                cyc_tot++;
                if (tready) cyc_rdy++;
            end
        end
    end

    // Frame-level reference: beat i of a burst is in-frame while i < L; tlast only on the final beat
    task automatic send_burst(input int n, input bit has_last, input int bad_idx,
                              input logic [DW-1:0] bad_val, input bit clr_last);
        int            len;
        bit            rst_seq, chk_en, fbad, last, clr;
        logic [DW-1:0] start, d, e;
        snap_t         s;
        int            w;
        len     = (confi[7:0] == 8'd0) ? 256 : int'(confi[7:0]);
        rst_seq = confi[12];
        chk_en  = confi[13];
        start   = rst_seq ? '0 : m_exp;
        fbad    = 1'b0;
        for (int i = 0; i < n; i++) begin
            last = has_last && (i == n - 1);
            d    = (i == bad_idx) ? bad_val : start + DW'(i);
            if (i < len) begin
                e = (i == 0 && rst_seq) ? '0 : m_exp;
                if (chk_en && d != e) begin
                    m_derr     = sat(m_derr);
                    m_flags[2] = 1'b1;
                    fbad       = 1'b1;
                end
                m_exp = d + 1'b1;
                if (last) begin
                    if (i != len - 1) begin
                        m_flags[0] = 1'b1;
                        fbad       = 1'b1;
                    end
                    if (fbad) m_bad = sat(m_bad);
                    else      m_ok  = sat(m_ok);
                end else if (i == len - 1) begin
                    m_flags[1] = 1'b1;
                    m_bad      = sat(m_bad);
                end
            end
            clr = clr_last && last;
            if (clr) begin
                m_ok = '0; m_bad = '0; m_derr = '0; m_flags = '0;
            end
            s = '{m_ok, m_bad, m_derr, m_flags, !last};

            while ($urandom_range(0, 3) == 0) @(negedge clk);
            tdata  = d;
            tlast  = last;
            tvalid = 1'b1;
            w = 0;
            while (!tready && w < 1000) begin
                @(negedge clk);
                w++;
            end
            if (!tready) begin
                checks++;
                failures++;
                $display("FAIL beat_timeout actual=no_ready required=ready_within_1000");
                tvalid = 1'b0;
                tlast  = 1'b0;
                return;
            end
            clear_err = clr;
            sbq.push_back(s);
            @(negedge clk);
            tvalid    = 1'b0;
            tlast     = 1'b0;
            clear_err = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b0;
        tvalid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_frames_ok", 32'(frames_ok), 32'd0);
        chk("rst_frames_bad", 32'(frames_bad), 32'd0);
        chk("rst_err_data", 32'(err_data_count), 32'd0);
        chk("rst_err_flags", 32'(err_flags), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_tready", 32'(tready), 32'd0);
        m_exp = '0; m_ok = '0; m_bad = '0; m_derr = '0; m_flags = '0;
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic set_cfg(input logic [15:0] c);
        confi = c;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int          len, n, mode, bad_idx;
        bit          big_done;
        logic [15:0] c;

        do_reset();

        set_cfg(16'h1010);
        cyc_tot = 0; cyc_rdy = 0; cnt_en = 1'b1;
        repeat (3) send_burst(16, 1'b1, -1, '0, 1'b0);
        cnt_en = 1'b0;
        chk("tready_always_high", 32'(cyc_rdy), 32'(cyc_tot));

        do_reset();
        set_cfg(16'h2010);
        send_burst(10, 1'b1, -1, '0, 1'b0);
        send_burst(16, 1'b1, -1, '0, 1'b0);

        do_reset();
        set_cfg(16'h2010);
        send_burst(20, 1'b1, -1, '0, 1'b0);
        send_burst(16, 1'b1, -1, '0, 1'b0);

        do_reset();
        set_cfg(16'h3010);
        send_burst(16, 1'b1, 5, 8'hAA, 1'b0);

        do_reset();
        set_cfg(16'h2810);
        cyc_tot = 0; cyc_rdy = 0; cnt_en = 1'b1;
        repeat (4) send_burst(16, 1'b1, -1, '0, 1'b0);
        cnt_en = 1'b0;
        chk("throttle_duty_low", 32'(cyc_rdy * 10 >= cyc_tot * 3), 32'd1);
        chk("throttle_duty_high", 32'(cyc_rdy * 10 <= cyc_tot * 7), 32'd1);
        chk("throttle_seq_end", 32'(m_exp), 32'd64);

        set_cfg(16'h3010);
        send_burst(7, 1'b0, -1, '0, 1'b0);
        do_reset();
        set_cfg(16'h3010);
        send_burst(16, 1'b1, -1, '0, 1'b0);

        do_reset();
        set_cfg(16'h2010);
        send_burst(5, 1'b1, -1, '0, 1'b0);
        send_burst(5, 1'b1, -1, '0, 1'b0);
        send_burst(5, 1'b1, -1, '0, 1'b1);

        big_done = 1'b0;
        for (int k = 0; k < 40; k++) begin
            case ($urandom_range(0, 6))
                0: len = 1;
                1: len = 2;
                2: len = 3;
                3: len = 5;
                4: len = 8;
                5: len = 16;
                default: len = big_done ? 4 : 256;
            endcase
            if (len == 256) big_done = 1'b1;
            c = '0;
            c[7:0]  = 8'(len);
            c[11:8] = 4'($urandom_range(0, 15));
            c[12]   = 1'($urandom_range(0, 1));
            c[13]   = ($urandom_range(0, 3) != 0);
            set_cfg(c);
            mode = $urandom_range(0, 2);
            if (mode == 1 && len > 1) n = $urandom_range(1, len - 1);
            else if (mode == 2)       n = len + $urandom_range(1, 4);
            else                      n = len;
            bad_idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
            send_burst(n, 1'b1, bad_idx, DW'($urandom), ($urandom_range(0, 7) == 0));
        end

        repeat (4) @(negedge clk);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
